// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control sequencer
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_JREG     = 4'd12,
    ST_ILLEGAL  = 4'd13,
    ST_TRAP     = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;

  localparam logic [3:0] ALU_NOR = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;

  localparam logic [1:0] PC_SRC_BRANCH = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_RS     = 2'b10;
  localparam logic [1:0] PC_SRC_INC    = 2'b11;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MDR = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'd2;

  localparam logic       ORIG_A_PC = 1'b0;
  localparam logic       ORIG_A_RS = 1'b1;

  localparam logic [1:0] ORIG_B_RT  = 2'd0;
  localparam logic [1:0] ORIG_B_ONE = 2'd1;
  localparam logic [1:0] ORIG_B_IMM = 2'd2;

  // JR/JALR are R-type encodings that bypass the ALU and go straight to the PC
  function automatic logic is_jreg(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - IR fields, memory handshake and datapath strobes
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       write_enable_mem;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       write_enable_reg;
  logic [3:0] opALU;
  logic       origALU_a;
  logic [1:0] origALU_b;

  // controller side
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_src, ir_write, i_or_d, mem_read, write_enable_mem,
           reg_dst, mem_to_reg, write_enable_reg, opALU, origALU_a, origALU_b
  );

  // datapath side
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_src, ir_write, i_or_d, mem_read, write_enable_mem,
           reg_dst, mem_to_reg, write_enable_reg, opALU, origALU_a, origALU_b
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// rtl/multicycle_ctrl_alu_dec.sv - funct/opcode to ALU operation decode
module multicycle_ctrl_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);

  // R-type decodes funct, immediate ops decode opcode; unknown codes fall back to ADD
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: alu_op = ALU_ADD;
        FN_SUB, FN_SUBU: alu_op = ALU_SUB;
        FN_AND:          alu_op = ALU_AND;
        FN_OR:           alu_op = ALU_OR;
        FN_XOR:          alu_op = ALU_XOR;
        FN_NOR:          alu_op = ALU_NOR;
        default:         valid  = 1'b0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI: alu_op = ALU_ADD;
        OP_ANDI: alu_op = ALU_AND;
        OP_ORI:  alu_op = ALU_OR;
        OP_XORI: alu_op = ALU_XOR;
        default: valid  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS sequencer (option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN)
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus,
  output logic [3:0]          state,
  output logic [RETIRE_W-1:0] retire_count
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_instr
`endif
);

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                retire;

  logic       pc_write, ir_write, i_or_d, mem_read, we_mem, we_reg, orig_a;
  logic [1:0] pc_src, reg_dst, mem_to_reg, orig_b;
  logic [3:0] alu_op;

  logic [3:0] dec_op;
  logic       dec_valid;

  multicycle_ctrl_alu_dec u_alu_dec (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .alu_op (dec_op),
    .valid  (dec_valid)
  );

  // state and retired-instruction counter; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
    end
  end

  // next state, retire decision and all datapath strobes
  always_comb begin
    state_d    = ST_FETCH;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_INC;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    we_mem     = 1'b0;
    we_reg     = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = MEM_TO_REG_ALU;
    alu_op     = ALU_ADD;
    orig_a     = ORIG_A_PC;
    orig_b     = ORIG_B_RT;

    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        state_d  = ST_FETCH;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          orig_b   = ORIG_B_ONE;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // speculatively compute the branch target into ALUOut
        orig_b = ORIG_B_IMM;
        if (is_jreg(bus.opcode, bus.funct)) state_d = ST_JREG;
        else begin
          case (bus.opcode)
            OP_RTYPE:                          state_d = ST_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = ST_EXEC_I;
            OP_LW, OP_SW:                      state_d = ST_MEM_ADDR;
            OP_BEQ:                            state_d = ST_BRANCH;
            OP_J, OP_JAL:                      state_d = ST_JUMP;
            default:                           state_d = ST_ILLEGAL;
          endcase
        end
      end
      ST_EXEC_R: begin
        orig_a  = ORIG_A_RS;
        alu_op  = dec_op;
        // an unknown funct is dropped without writing or retiring
        state_d = dec_valid ? ST_WB_R : ST_FETCH;
      end
      ST_WB_R: begin
        we_reg  = 1'b1;
        reg_dst = REG_DST_RD;
        retire  = 1'b1;
      end
      ST_EXEC_I: begin
        orig_a  = ORIG_A_RS;
        orig_b  = ORIG_B_IMM;
        alu_op  = dec_op;
        state_d = ST_WB_I;
      end
      ST_WB_I: begin
        we_reg = 1'b1;
        retire = 1'b1;
      end
      ST_MEM_ADDR: begin
        orig_a  = ORIG_A_RS;
        orig_b  = ORIG_B_IMM;
        state_d = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = bus.mem_ready ? ST_WB_MEM : ST_MEM_RD;
      end
      ST_WB_MEM: begin
        we_reg     = 1'b1;
        mem_to_reg = MEM_TO_REG_MDR;
        retire     = 1'b1;
      end
      ST_MEM_WR: begin
        we_mem  = 1'b1;
        i_or_d  = 1'b1;
        retire  = bus.mem_ready;
        state_d = bus.mem_ready ? ST_FETCH : ST_MEM_WR;
      end
      ST_BRANCH: begin
        orig_a   = ORIG_A_RS;
        alu_op   = ALU_SUB;
        pc_src   = PC_SRC_BRANCH;
        pc_write = bus.zero;
        retire   = 1'b1;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        retire   = 1'b1;
        // PC already holds PC+1, which is the link value
        if (bus.opcode == OP_JAL) begin
          we_reg     = 1'b1;
          reg_dst    = REG_DST_R31;
          mem_to_reg = MEM_TO_REG_PC;
        end
      end
      ST_JREG: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_RS;
        retire   = 1'b1;
        if (bus.funct == FN_JALR) begin
          we_reg     = 1'b1;
          reg_dst    = REG_DST_RD;
          mem_to_reg = MEM_TO_REG_PC;
        end
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      ST_ILLEGAL: state_d = ST_TRAP;
      ST_TRAP:    state_d = ST_TRAP;
`else
      ST_ILLEGAL: retire = 1'b1;
`endif
      default: state_d = ST_FETCH;
    endcase

    retire_d = retire ? retire_q + RETIRE_W'(1) : retire_q;
  end

  assign bus.pc_write         = pc_write;
  assign bus.pc_src           = pc_src;
  assign bus.ir_write         = ir_write;
  assign bus.i_or_d           = i_or_d;
  assign bus.mem_read         = mem_read;
  assign bus.write_enable_mem = we_mem;
  assign bus.reg_dst          = reg_dst;
  assign bus.mem_to_reg       = mem_to_reg;
  assign bus.write_enable_reg = we_reg;
  assign bus.opALU            = alu_op;
  assign bus.origALU_a        = orig_a;
  assign bus.origALU_b        = orig_b;

  assign state        = state_q;
  assign retire_count = retire_q;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == ST_TRAP);
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle sequencer for the MIPS datapath. Replaces the single-cycle control decode with a registered FSM.
- Drives one shared instruction/data memory port, the IR latch, the PC and the register-file write port across several cycles per instruction.
- Sits between the instruction register fields (opcode/funct) and the datapath muxes; the ALU opcode encoding and the pc_src encoding are unchanged.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory handshake: access completes in the cycle it is high.
- pc_write  out  1  PC register load strobe.
- pc_src  out  2  00 branch target, 01 jump target, 10 rs, 11 PC+1.
- ir_write  out  1  IR load strobe.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- write_enable_mem  out  1  memory write request.
- reg_dst  out  2  0 rt, 1 rd, 2 r31.
- mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 PC.
- write_enable_reg  out  1  register-file write strobe.
- opALU  out  4  0 NOR, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
- origALU_a  out  1  0 = PC, 1 = rs.
- origALU_b  out  2  0 rt, 1 constant 1, 2 sign-extended immediate.
- state  out  4  current state, for debug.
- retire_count  out  RETIRE_W  instructions completed; wraps at 2^RETIRE_W.

Behaviour:
- Reset (async): state=FETCH, retire_count=0. Outputs then follow the FETCH decode with mem_ready low.
- Output timing: all outputs are combinational from the state register plus mem_ready/zero/opcode/funct. The state register updates on the clk rising edge.
- Strobe defaults: every strobe not listed for a state is 0; opALU defaults to ADD.
- FETCH: mem_read=1, i_or_d=0.
  - Wait here while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=11, origALU_a=0, origALU_b=1, then go to DECODE.
- DECODE (1 cycle): origALU_a=0, origALU_b=2, opALU=ADD (branch target into ALUOut). Next state:
  - R-type (opcode 000000) with funct JR/JALR -> JREG.
  - Other R-type -> EXEC_R.
  - ADDI/ANDI/ORI/XORI -> EXEC_I.
  - LW/SW -> MEM_ADDR.
  - BEQ (000100) -> BRANCH.
  - J/JAL -> JUMP.
  - Anything else -> ILLEGAL.
- EXEC_R: origALU_a=1, origALU_b=0. opALU by funct: ADD/ADDU=1, SUB/SUBU=2, AND=3, OR=4, XOR=5, NOR=0. Unknown funct -> FETCH with no write, no retire. Otherwise -> WB_R.
- WB_R: write_enable_reg=1, reg_dst=1, mem_to_reg=0. Retire; -> FETCH.
- EXEC_I: origALU_a=1, origALU_b=2, opALU per opcode. -> WB_I.
- WB_I: write_enable_reg=1, reg_dst=0, mem_to_reg=0. Retire; -> FETCH.
- MEM_ADDR: origALU_a=1, origALU_b=2, opALU=ADD. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then -> WB_MEM.
- WB_MEM: write_enable_reg=1, reg_dst=0, mem_to_reg=1. Retire; -> FETCH.
- MEM_WR: write_enable_mem=1, i_or_d=1. Hold until mem_ready=1, then retire; -> FETCH.
- BRANCH: origALU_a=1, origALU_b=0, opALU=SUB, pc_src=00. pc_write=zero. Retire; -> FETCH.
- JUMP: pc_write=1, pc_src=01. For JAL also write_enable_reg=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+1). Retire; -> FETCH.
- JREG: pc_write=1, pc_src=10. For JALR also write_enable_reg=1, reg_dst=1, mem_to_reg=2. Retire; -> FETCH.
- ILLEGAL: no strobes. Treated as NOP: retire; -> FETCH.
- Cycle counts with zero-wait memory: R/I-type 4, LW 5, SW 4, BEQ 3, J/JAL/JR/JALR 3. Each mem_ready=0 cycle adds 1.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Retire: retire_count increments by 1 in the cycle the FSM leaves a completing state.
- Reset asserted mid-instruction aborts immediately. No further strobes are issued; retire_count is cleared.
- Unused state encodings -> FETCH.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- When defined: ILLEGAL goes to TRAP instead of FETCH. TRAP is terminal: no strobes, no retire, left only by reset. An extra port illegal_instr (out, 1) is high while in TRAP.
- When undefined: the NOP behaviour above applies and the port does not exist.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum;
  - opcode and funct constants;
  - ALU_OP constants (NOR=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5);
  - PC_SRC constants;
  - REG_DST, MEM_TO_REG and ORIG_B encodings.
- One sub-module, multicycle_ctrl_alu_dec: combinational funct/opcode -> opALU plus a valid flag. It is reused by EXEC_R and EXEC_I.

Test Plan:
- Reset mid-MEM_RD (LW, mem_ready=0) -> state=FETCH, write_enable_reg=0, retire_count=0 on the next edge.
- ADD (opcode 0, funct 100000), mem_ready always 1 -> 4 cycles. In WB_R: write_enable_reg=1, reg_dst=1. In EXEC_R: opALU=1. retire_count=1.
- LW, mem_ready low for 3 cycles in FETCH and 2 in MEM_RD -> 10 cycles total. WB_MEM shows mem_to_reg=1.
- SW -> write_enable_mem high exactly while in MEM_WR. write_enable_reg never 1.
- BEQ with zero=1 -> pc_write=1, pc_src=00. BEQ with zero=0 -> pc_write=0. Both take 3 cycles.
- Opcode 111111 -> NOP, retire_count increments. With MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: illegal_instr=1, FSM stuck in TRAP until reset.
